// File: rtl/qubit_shot_scheduler_pkg.sv
// qrng_pkg: shared types and constants for the qubit shot scheduler.
// FSM states, synchroniser depth and PMOD pin levels.
package qrng_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_REL,
        S_DONE,
        S_ERR
    } state_t;

    localparam int   SYNC_DEPTH = 2;
    localparam logic PIN_ACTIVE = 1'b0;
    localparam logic PIN_IDLE   = 1'b1;

endpackage

// File: rtl/qubit_shot_scheduler_if.sv
// qubit_shot_scheduler_if: PMOD shot handshake between scheduler and MCU.
// master is the scheduler side, slave is the MCU side.
interface qubit_shot_scheduler_if;

    logic meas_req;
    logic meas_ack_n;
    logic meas_bit_n;

    modport master (
        output meas_req,
        input  meas_ack_n,
        input  meas_bit_n
    );

    modport slave (
        input  meas_req,
        output meas_ack_n,
        output meas_bit_n
    );

endinterface

// File: rtl/qubit_shot_scheduler_sync.sv
// qubit_sync: N-flop synchroniser for asynchronous PMOD pins.
// Flops reset to RST_VAL so an idle pin reads inactive after reset.
module qubit_sync
    import qrng_pkg::*;
#(
    parameter int   N       = SYNC_DEPTH,
    parameter logic RST_VAL = PIN_IDLE
) (
    input  logic clk0,
    input  logic rst0,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    // shift the pin through the flop chain
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            ff <= {N{RST_VAL}};
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/qubit_shot_scheduler.sv
// qubit_shot_scheduler: shot sequencer over the PMOD req/ack link.
// Define QRNG_DEBIAS_EN for von Neumann debiased rnd_bit output.
module qubit_shot_scheduler
    import qrng_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int NUM_SHOTS = 256,
    parameter int TO_CYCLES = 1024
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   start,
    qubit_shot_scheduler_if.master pmod,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       count0,
    output logic [CNT_W-1:0]       count1,
    output logic                   rnd_bit,
    output logic                   rnd_valid,
    output logic [3:0]             led
);

    localparam int SH_W = $clog2(NUM_SHOTS + 1);
    localparam int TM_W = $clog2(TO_CYCLES + 1);

    localparam logic [SH_W-1:0]  SHOT_LAST = SH_W'(NUM_SHOTS - 1);
    localparam logic [TM_W-1:0]  TM_LAST   = TM_W'(TO_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t          state;
    state_t          state_nx;
    logic            ack_raw;
    logic            bit_raw;
    logic            ack_s;
    logic            bit_s;
    logic [TM_W-1:0] timer;
    logic [SH_W-1:0] shots;
    logic            run_start;
    logic            shot_end;
    logic            timed_out;

    qubit_sync #(
        .N       (SYNC_DEPTH),
        .RST_VAL (PIN_IDLE)
    ) u_ack_sync (
        .clk0 (clk0),
        .rst0 (rst0),
        .d    (pmod.meas_ack_n),
        .q    (ack_raw)
    );

    qubit_sync #(
        .N       (SYNC_DEPTH),
        .RST_VAL (PIN_IDLE)
    ) u_bit_sync (
        .clk0 (clk0),
        .rst0 (rst0),
        .d    (pmod.meas_bit_n),
        .q    (bit_raw)
    );

    assign ack_s = (ack_raw == PIN_ACTIVE);
    assign bit_s = (bit_raw == PIN_ACTIVE);

    // state register
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic; ack wins over a coincident timeout
    always_comb begin
        state_nx  = state;
        run_start = 1'b0;
        shot_end  = 1'b0;
        timed_out = (timer == TM_LAST);
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_REQ;
                    run_start = 1'b1;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    state_nx = S_CAPT;
                end else if (timed_out) begin
                    state_nx = S_ERR;
                end
            end
            S_CAPT: begin
                state_nx = S_REL;
            end
            S_REL: begin
                if (!ack_s) begin
                    shot_end = 1'b1;
                    state_nx = (shots == SHOT_LAST) ? S_DONE : S_REQ;
                end else if (timed_out) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            S_ERR: begin
                if (!ack_s && !start) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign pmod.meas_req = (state == S_REQ);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign led           = count1[3:0] - count0[3:0];

    // per-phase timer, restarted on every state change
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            timer <= '0;
        end else if (state_nx != state) begin
            timer <= '0;
        end else if (state == S_REQ || state == S_REL) begin
            timer <= timer + 1'b1;
        end
    end

    // shots completed in this run
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            shots <= '0;
        end else if (run_start) begin
            shots <= '0;
        end else if (shot_end) begin
            shots <= shots + 1'b1;
        end
    end

    // sticky timeout flag, cleared only by an accepted start
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            timeout_err <= 1'b0;
        end else if (run_start) begin
            timeout_err <= 1'b0;
        end else if (state_nx == S_ERR) begin
            timeout_err <= 1'b1;
        end
    end

    // saturating outcome tallies
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            count0 <= '0;
            count1 <= '0;
        end else if (run_start) begin
            count0 <= '0;
            count1 <= '0;
        end else if (state == S_CAPT) begin
            if (bit_s && count1 != CNT_MAX) begin
                count1 <= count1 + 1'b1;
            end
            if (!bit_s && count0 != CNT_MAX) begin
                count0 <= count0 + 1'b1;
            end
        end
    end

`ifdef QRNG_DEBIAS_EN
    logic pair_half;
    logic pair_first;

    // pair register: holds the first shot of each pair
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            pair_half  <= 1'b0;
            pair_first <= 1'b0;
        end else if (run_start) begin
            pair_half  <= 1'b0;
            pair_first <= 1'b0;
        end else if (state == S_CAPT) begin
            pair_half <= ~pair_half;
            if (!pair_half) begin
                pair_first <= bit_s;
            end
        end
    end

    // 01 gives 0, 10 gives 1, equal pairs are dropped
    always_comb begin
        rnd_valid = (state == S_CAPT) && pair_half && (pair_first != bit_s);
        rnd_bit   = rnd_valid & pair_first;
    end
`else
    assign rnd_valid = (state == S_CAPT);
    assign rnd_bit   = rnd_valid & bit_s;
`endif

endmodule

// File: tb/tb_qubit_shot_scheduler.sv
// tb_qubit_shot_scheduler: randomized MCU model with a run-level reference.
// Two instances: wide counters (A) and 4-bit saturating counters (B).
module tb_qubit_shot_scheduler;

    localparam int TO = 40;
    localparam int NA = 8;
    localparam int NB = 20;

    logic clk0 = 1'b0;
    logic rst0 = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        busy_a, done_a, terr_a, rbit_a, rval_a;
    logic [15:0] c0_a, c1_a;
    logic [3:0]  led_a;
    logic        busy_b, done_b, terr_b, rbit_b, rval_b;
    logic [3:0]  c0_b, c1_b;
    logic [3:0]  led_b;

    qubit_shot_scheduler_if ifa ();
    qubit_shot_scheduler_if ifb ();

    always #5 clk0 = ~clk0;

    qubit_shot_scheduler #(
        .CNT_W     (16),
        .NUM_SHOTS (NA),
        .TO_CYCLES (TO)
    ) u_a (
        .clk0        (clk0),
        .rst0        (rst0),
        .start       (start_a),
        .pmod        (ifa),
        .busy        (busy_a),
        .done        (done_a),
        .timeout_err (terr_a),
        .count0      (c0_a),
        .count1      (c1_a),
        .rnd_bit     (rbit_a),
        .rnd_valid   (rval_a),
        .led         (led_a)
    );

    qubit_shot_scheduler #(
        .CNT_W     (4),
        .NUM_SHOTS (NB),
        .TO_CYCLES (TO)
    ) u_b (
        .clk0        (clk0),
        .rst0        (rst0),
        .start       (start_b),
        .pmod        (ifb),
        .busy        (busy_b),
        .done        (done_b),
        .timeout_err (terr_b),
        .count0      (c0_b),
        .count1      (c1_b),
        .rnd_bit     (rbit_b),
        .rnd_valid   (rval_b),
        .led         (led_b)
    );

    int checks = 0;
    int errors = 0;

    bit sent_a[$];
    bit bits_a[$];
    bit obs_a[$];
    bit sent_b[$];
    bit bits_b[$];
    int reqs_a = 0;
    int dones_a = 0;
    int reqs_b = 0;
    int dones_b = 0;
    int mode_a = 0;
    bit hold_a = 1'b0;
    bit glitch_a = 1'b0;
    int exp_c0_a = 0;
    int exp_c1_a = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int led_of(input int c1, input int c0);
        return ((c1 % 16) - (c0 % 16) + 16) % 16;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // MCU model for A: random delays, optional no-ack / stuck-ack / glitch
    initial begin : mcu_a
        logic b;
        ifa.meas_ack_n = 1'b1;
        ifa.meas_bit_n = 1'b1;
        forever begin
            @(negedge clk0);
            if (ifa.meas_req && mode_a == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk0);
                b = (bits_a.size() > 0) ? bits_a.pop_front()
                                        : 1'($urandom_range(0, 1));
                ifa.meas_bit_n = ~b;
                @(negedge clk0);
                ifa.meas_ack_n = 1'b0;
                sent_a.push_back(b);
                while (ifa.meas_req || hold_a) @(negedge clk0);
                repeat ($urandom_range(0, 3)) @(negedge clk0);
                ifa.meas_ack_n = 1'b1;
            end else begin
                ifa.meas_ack_n = ~glitch_a;
            end
        end
    end

    // MCU model for B: prompt acks
    initial begin : mcu_b
        logic b;
        ifb.meas_ack_n = 1'b1;
        ifb.meas_bit_n = 1'b1;
        forever begin
            @(negedge clk0);
            if (ifb.meas_req) begin
                b = (bits_b.size() > 0) ? bits_b.pop_front() : 1'b1;
                ifb.meas_bit_n = ~b;
                @(negedge clk0);
                ifb.meas_ack_n = 1'b0;
                sent_b.push_back(b);
                while (ifb.meas_req) @(negedge clk0);
                ifb.meas_ack_n = 1'b1;
            end
        end
    end

    // per-cycle compare and event collection
    initial begin : compare
        logic rq_a = 1'b0;
        logic rq_b = 1'b0;
        logic dn_a = 1'b0;
        forever begin
            @(negedge clk0);
            if (!rst0) begin
                check("led_a", led_a, led_of(int'(c1_a), int'(c0_a)));
                check("led_b", led_b, led_of(int'(c1_b), int'(c0_b)));
                if (ifa.meas_req || done_a || rval_a)
                    check("busy_a", busy_a, 1);
                if (done_a) begin
                    check("done_a_pulse", dn_a, 0);
                    dones_a++;
                end
                if (done_b) dones_b++;
                if (rval_a) obs_a.push_back(rbit_a);
                if (ifa.meas_req && !rq_a) reqs_a++;
                if (ifb.meas_req && !rq_b) reqs_b++;
            end
            rq_a = ifa.meas_req;
            rq_b = ifb.meas_req;
            dn_a = done_a;
        end
    end

    task automatic clear_a();
        sent_a.delete();
        obs_a.delete();
        reqs_a  = 0;
        dones_a = 0;
    endtask

    task automatic verify_a();
        int ones;
        int zeros;
        bit e[$];
        ones = 0;
        foreach (sent_a[i]) ones += int'(sent_a[i]);
        zeros = sent_a.size() - ones;
        exp_c1_a = ones;
        exp_c0_a = zeros;
        check("a_shots", sent_a.size(), NA);
        check("a_reqs", reqs_a, NA);
        check("a_dones", dones_a, 1);
        check("a_count1", c1_a, ones);
        check("a_count0", c0_a, zeros);
        check("a_led", led_a, led_of(ones, zeros));
        check("a_idle", busy_a, 0);
`ifdef QRNG_DEBIAS_EN
        for (int i = 0; i + 1 < sent_a.size(); i += 2) begin
            if ({sent_a[i], sent_a[i+1]} == 2'b01) e.push_back(1'b0);
            if ({sent_a[i], sent_a[i+1]} == 2'b10) e.push_back(1'b1);
        end
`else
        e = sent_a;
`endif
        check("a_rnd_count", obs_a.size(), e.size());
        for (int i = 0; i < e.size() && i < obs_a.size(); i++)
            check("a_rnd_bit", obs_a[i], e[i]);
    endtask

    task automatic run_a(input bit pulse_busy);
        bit ok;
        clear_a();
        @(negedge clk0);
        start_a = 1'b1;
        @(negedge clk0);
        start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk0);
            start_a = pulse_busy && (i == 20);
            if (dones_a > 0) begin
                ok = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
        check("a_done_seen", ok, 1);
        repeat (3) @(negedge clk0);
        verify_a();
    endtask

    task automatic run_b();
        bit ok;
        int ones;
        int zeros;
        sent_b.delete();
        reqs_b  = 0;
        dones_b = 0;
        @(negedge clk0);
        start_b = 1'b1;
        @(negedge clk0);
        start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk0);
            if (dones_b > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_done_seen", ok, 1);
        repeat (3) @(negedge clk0);
        ones = 0;
        foreach (sent_b[i]) ones += int'(sent_b[i]);
        zeros = sent_b.size() - ones;
        check("b_reqs", reqs_b, NB);
        check("b_dones", dones_b, 1);
        check("b_count1", c1_b, sat(ones, 15));
        check("b_count0", c0_b, sat(zeros, 15));
        check("b_led", led_b, led_of(sat(ones, 15), sat(zeros, 15)));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int n;
        #2;
        check("rst_outs_a", |{ifa.meas_req, busy_a, done_a, terr_a, c0_a,
                              c1_a, rbit_a, rval_a, led_a}, 0);
        check("rst_outs_b", |{ifb.meas_req, busy_b, done_b, terr_b, c0_b,
                              c1_b, rbit_b, rval_b, led_b}, 0);
        repeat (3) @(negedge clk0);
        rst0 = 1'b0;
        repeat (4) @(negedge clk0);

        bits_a = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_a(1'b0);
        check("lit1_count1", c1_a, 4);
        check("lit1_count0", c0_a, 4);
        check("lit1_led", led_a, 4'h0);
`ifdef QRNG_DEBIAS_EN
        check("lit1_strobes", obs_a.size(), 2);
        if (obs_a.size() == 2) begin
            check("lit1_rnd0", obs_a[0], 0);
            check("lit1_rnd1", obs_a[1], 1);
        end
`else
        check("lit1_strobes", obs_a.size(), 8);
        if (obs_a.size() == 8) begin
            check("lit1_rnd1", obs_a[1], 1);
            check("lit1_rnd7", obs_a[7], 0);
        end
`endif

        bits_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_a(1'b1);
        check("lit2_count1", c1_a, 6);
        check("lit2_count0", c0_a, 2);
        check("lit2_led", led_a, 4'h4);

        clear_a();
        glitch_a = 1'b1;
        repeat (4) @(negedge clk0);
        glitch_a = 1'b0;
        repeat (10) @(negedge clk0);
        check("glitch_busy", busy_a, 0);
        check("glitch_reqs", reqs_a, 0);
        check("glitch_count1", c1_a, exp_c1_a);
        check("glitch_count0", c0_a, exp_c0_a);

        clear_a();
        mode_a = 1;
        @(negedge clk0);
        start_a = 1'b1;
        @(negedge clk0);
        start_a = 1'b0;
        n = 0;
        for (int i = 1; i <= TO + 20; i++) begin
            if (terr_a) break;
            @(negedge clk0);
            n = i;
        end
        check("to_flag", terr_a, 1);
        check("to_latency", (n >= TO) && (n <= TO + 2), 1);
        check("to_req_low", ifa.meas_req, 0);
        mode_a = 0;
        repeat (6) @(negedge clk0);
        check("to_back_idle", busy_a, 0);
        check("to_sticky", terr_a, 1);
        run_a(1'b0);
        check("to_cleared", terr_a, 0);

        clear_a();
        hold_a = 1'b1;
        @(negedge clk0);
        start_a = 1'b1;
        @(negedge clk0);
        start_a = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (terr_a) break;
            @(negedge clk0);
        end
        check("rel_to_flag", terr_a, 1);
        check("rel_to_counts", int'(c0_a) + int'(c1_a), 1);
        check("rel_to_busy", busy_a, 1);
        hold_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk0);
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("rel_to_idle", ok, 1);

        clear_a();
        @(negedge clk0);
        start_a = 1'b1;
        @(negedge clk0);
        start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk0);
            if (reqs_a >= 3 && ifa.meas_req && !ifa.meas_ack_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_reached", ok, 1);
        #1 rst0 = 1'b1;
        #1;
        check("mid_rst_outs", |{ifa.meas_req, busy_a, done_a, terr_a, c0_a,
                                c1_a, rbit_a, rval_a, led_a}, 0);
        repeat (3) @(negedge clk0);
        rst0 = 1'b0;
        repeat (6) @(negedge clk0);
        run_a(1'b0);

        for (int r = 0; r < 6; r++) run_a(1'($urandom_range(0, 1)));

        for (int i = 0; i < NB; i++) bits_b.push_back(1'b1);
        run_b();
        check("lit_b_count1", c1_b, 15);
        check("lit_b_count0", c0_b, 0);
        check("lit_b_led", led_b, 4'hF);

        for (int i = 0; i < NB; i++) bits_b.push_back(i < 17 ? 1'b0 : 1'b1);
        run_b();
        check("lit_b2_count0", c0_b, 15);
        check("lit_b2_count1", c1_b, 3);
        check("lit_b2_led", led_b, 4'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
